// File: rtl/tag_pool_if.sv
// Tag manager bundle: allocation, completion reports, drain handshake and pool status.
// master = requester/completion/drain side, slave = tag_pool_mgr.
interface tag_pool_if #(
    parameter int unsigned TAG_W = 5,
    parameter int unsigned LEN_W = 11
);
    logic             alloc_req;
    logic             alloc_last;
    logic [LEN_W-1:0] alloc_len;
    logic             alloc_ack;
    logic [TAG_W-1:0] alloc_tag;
    logic             cpl_vld;
    logic [TAG_W-1:0] cpl_tag;
    logic [LEN_W-1:0] cpl_len;
    logic             rd_req;
    logic             rd_ack;
    logic [TAG_W-1:0] rd_tag;
    logic [LEN_W-1:0] rd_len;
    logic             rd_last;
    logic             rd_done;
    logic [TAG_W:0]   outstanding;
    logic             full;
    logic             empty;
    logic             err_cpl;

    modport master (
        output alloc_req, alloc_last, alloc_len, cpl_vld, cpl_tag, cpl_len, rd_ack, rd_done,
        input  alloc_ack, alloc_tag, rd_req, rd_tag, rd_len, rd_last, outstanding, full, empty,
               err_cpl
    );

    modport slave (
        input  alloc_req, alloc_last, alloc_len, cpl_vld, cpl_tag, cpl_len, rd_ack, rd_done,
        output alloc_ack, alloc_tag, rd_req, rd_tag, rd_len, rd_last, outstanding, full, empty,
               err_cpl
    );
endinterface

// File: rtl/tag_pool_mgr.sv
// DMA read-tag manager: ring-order tag allocation, per-tag completion accumulation,
// and in-order release of completed tags to the RX drain.
module tag_pool_mgr #(
    parameter int unsigned TAG_W     = 5,
    parameter int unsigned LEN_W     = 11,
    parameter int unsigned MAX_OUTST = 32
) (
    input logic        clk,
    input logic        rst,
    tag_pool_if.slave  bus
);
    localparam int unsigned TAG_NUM = 2 ** TAG_W;
    localparam int unsigned CNT_W   = TAG_W + 1;

    typedef enum logic [1:0] {StIdle, StReq, StBusy} drain_st_e;

    logic [TAG_NUM-1:0] used_q;
    logic [TAG_NUM-1:0] done_q;
    logic [TAG_NUM-1:0] last_q;
    logic [LEN_W-1:0]   req_len_q [TAG_NUM];
    logic [LEN_W-1:0]   acc_len_q [TAG_NUM];

    logic [TAG_W-1:0] alloc_ptr_q;
    logic [TAG_W-1:0] head_ptr_q;
    logic [TAG_W-1:0] alloc_tag_q;
    logic             alloc_ack_q;
    logic [CNT_W-1:0] outst_q;
    logic [CNT_W-1:0] outst_d;
    logic             full_q;
    logic             empty_q;
    logic             err_cpl_q;

    drain_st_e        state_q;
    logic             rd_req_q;
    logic [TAG_W-1:0] rd_tag_q;
    logic [LEN_W-1:0] rd_len_q;
    logic             rd_last_q;

    logic             grant;
    logic             free;
    logic             cpl_ok;
    logic [LEN_W:0]   cpl_sum;

    always_comb begin
        // Back-to-back grants are suppressed so the requester can drop alloc_req after ack.
        grant   = bus.alloc_req && !full_q && !alloc_ack_q;
        free    = (state_q == StBusy) && bus.rd_done;
        cpl_sum = {1'b0, acc_len_q[bus.cpl_tag]} + {1'b0, bus.cpl_len};
        cpl_ok  = used_q[bus.cpl_tag] && !done_q[bus.cpl_tag]
                  && (cpl_sum <= {1'b0, req_len_q[bus.cpl_tag]});
        outst_d = outst_q;
        if (grant && !free) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (free && !grant) begin
            outst_d = outst_q - CNT_W'(1);
        end
    end

    // Grant, completion and free never target the same tag in one cycle: the granted tag
    // is unused, and the freed tag is done so any completion to it is rejected.
    always_ff @(posedge clk) begin
        if (rst) begin
            used_q <= '0;
            done_q <= '0;
            last_q <= '0;
            for (int i = 0; i < TAG_NUM; i++) begin
                req_len_q[i] <= '0;
                acc_len_q[i] <= '0;
            end
        end else begin
            if (bus.cpl_vld && cpl_ok) begin
                acc_len_q[bus.cpl_tag] <= cpl_sum[LEN_W-1:0];
                if (cpl_sum == {1'b0, req_len_q[bus.cpl_tag]}) begin
                    done_q[bus.cpl_tag] <= 1'b1;
                end
            end
            if (free) begin
                used_q[rd_tag_q]    <= 1'b0;
                done_q[rd_tag_q]    <= 1'b0;
                acc_len_q[rd_tag_q] <= '0;
            end
            if (grant) begin
                used_q[alloc_ptr_q]    <= 1'b1;
                done_q[alloc_ptr_q]    <= (bus.alloc_len == '0);
                last_q[alloc_ptr_q]    <= bus.alloc_last;
                req_len_q[alloc_ptr_q] <= bus.alloc_len;
                acc_len_q[alloc_ptr_q] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr_q <= '0;
            alloc_tag_q <= '0;
            alloc_ack_q <= 1'b0;
            outst_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            err_cpl_q   <= 1'b0;
        end else begin
            alloc_ack_q <= grant;
            if (grant) begin
                alloc_tag_q <= alloc_ptr_q;
                alloc_ptr_q <= alloc_ptr_q + TAG_W'(1);
            end
            outst_q   <= outst_d;
            full_q    <= (outst_d == CNT_W'(MAX_OUTST));
            empty_q   <= (outst_d == '0);
            err_cpl_q <= bus.cpl_vld && !cpl_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            head_ptr_q <= '0;
            rd_req_q   <= 1'b0;
            rd_tag_q   <= '0;
            rd_len_q   <= '0;
            rd_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (used_q[head_ptr_q] && done_q[head_ptr_q]) begin
                        state_q   <= StReq;
                        rd_req_q  <= 1'b1;
                        rd_tag_q  <= head_ptr_q;
                        rd_len_q  <= req_len_q[head_ptr_q];
                        rd_last_q <= last_q[head_ptr_q];
                    end
                end
                StReq: begin
                    if (bus.rd_ack) begin
                        state_q  <= StBusy;
                        rd_req_q <= 1'b0;
                    end
                end
                StBusy: begin
                    if (bus.rd_done) begin
                        state_q    <= StIdle;
                        head_ptr_q <= head_ptr_q + TAG_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.alloc_ack   = alloc_ack_q;
    assign bus.alloc_tag   = alloc_tag_q;
    assign bus.rd_req      = rd_req_q;
    assign bus.rd_tag      = rd_tag_q;
    assign bus.rd_len      = rd_len_q;
    assign bus.rd_last     = rd_last_q;
    assign bus.outstanding = outst_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.err_cpl     = err_cpl_q;
endmodule

// File: tb/tb_tag_pool_mgr.sv
// Bench for tag_pool_mgr: completion-vector table plus scoreboard of expected drains.
module tb_tag_pool_mgr;
    localparam int unsigned TAG_W     = 5;
    localparam int unsigned LEN_W     = 11;
    localparam int unsigned MAX_OUTST = 4;
    localparam int unsigned TAG_NUM   = 2 ** TAG_W;

    typedef struct {
        int tag;
        int len;
        int last;
    } drain_t;

    typedef struct {
        int tag;
        int len;
        int exp_err;
        int exp_rd_req;
    } cpl_vec_t;

    logic clk;
    logic rst;

    tag_pool_if #(.TAG_W(TAG_W), .LEN_W(LEN_W)) tp ();

    tag_pool_mgr #(
        .TAG_W    (TAG_W),
        .LEN_W    (LEN_W),
        .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(tp.slave)
    );

    int     pass_cnt;
    int     chk_cnt;
    int     exp_tag;
    int     exp_outst;
    drain_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_tag   = 0;
        exp_outst = 0;
    endtask

    task automatic do_alloc(input int len, input bit last);
        int     n;
        drain_t e;
        n = 0;
        tp.alloc_req  = 1'b1;
        tp.alloc_len  = LEN_W'(len);
        tp.alloc_last = last;
        do begin
            @(negedge clk);
            n++;
        end while (!tp.alloc_ack && n < 20);
        tp.alloc_req = 1'b0;
        check("alloc_ack", int'(tp.alloc_ack), 1);
        check("alloc_tag", int'(tp.alloc_tag), exp_tag);
        e.tag  = exp_tag;
        e.len  = len;
        e.last = int'(last);
        exp_q.push_back(e);
        exp_tag = (exp_tag + 1) % TAG_NUM;
        exp_outst++;
        check("outstanding_alloc", int'(tp.outstanding), exp_outst);
    endtask

    task automatic send_cpl(input int tag, input int len, input int exp_err);
        tp.cpl_vld = 1'b1;
        tp.cpl_tag = TAG_W'(tag);
        tp.cpl_len = LEN_W'(len);
        @(negedge clk);
        tp.cpl_vld = 1'b0;
        check("err_cpl", int'(tp.err_cpl), exp_err);
    endtask

    task automatic drain_one();
        int     n;
        drain_t e;
        n = 0;
        while (!tp.rd_req && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("drain_rd_req", int'(tp.rd_req), 1);
        if (!tp.rd_req) return;
        if (exp_q.size() == 0) begin
            check("drain_unexpected", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check("rd_tag", int'(tp.rd_tag), e.tag);
        check("rd_len", int'(tp.rd_len), e.len);
        check("rd_last", int'(tp.rd_last), e.last);
        tp.rd_ack = 1'b1;
        @(negedge clk);
        tp.rd_ack = 1'b0;
        check("rd_req_drop", int'(tp.rd_req), 0);
        tp.rd_done = 1'b1;
        @(negedge clk);
        tp.rd_done = 1'b0;
        exp_outst--;
        check("outstanding_free", int'(tp.outstanding), exp_outst);
    endtask

    initial begin
        cpl_vec_t vecs[6];
        int       n;
        int       t0;
        drain_t   e;

        // Tag1 finishes first; tag0 must still drain first. Illegal ones leave state alone.
        vecs[0] = '{tag: 1, len: 16, exp_err: 0, exp_rd_req: 0};
        vecs[1] = '{tag: 1, len: 4,  exp_err: 1, exp_rd_req: 0};
        vecs[2] = '{tag: 0, len: 8,  exp_err: 0, exp_rd_req: 0};
        vecs[3] = '{tag: 5, len: 4,  exp_err: 1, exp_rd_req: 0};
        vecs[4] = '{tag: 0, len: 12, exp_err: 1, exp_rd_req: 0};
        vecs[5] = '{tag: 0, len: 8,  exp_err: 0, exp_rd_req: 1};

        pass_cnt      = 0;
        chk_cnt       = 0;
        rst           = 1'b1;
        tp.alloc_req  = 1'b0;
        tp.alloc_last = 1'b0;
        tp.alloc_len  = '0;
        tp.cpl_vld    = 1'b0;
        tp.cpl_tag    = '0;
        tp.cpl_len    = '0;
        tp.rd_ack     = 1'b0;
        tp.rd_done    = 1'b0;
        @(negedge clk);
        do_reset();

        check("rst_alloc_ack", int'(tp.alloc_ack), 0);
        check("rst_rd_req", int'(tp.rd_req), 0);
        check("rst_outstanding", int'(tp.outstanding), 0);
        check("rst_empty", int'(tp.empty), 1);
        check("rst_full", int'(tp.full), 0);
        check("rst_err_cpl", int'(tp.err_cpl), 0);

        do_alloc(16, 1'b0);
        do_alloc(16, 1'b0);
        do_alloc(16, 1'b1);
        check("outstanding_3", int'(tp.outstanding), 3);
        check("empty_3", int'(tp.empty), 0);

        foreach (vecs[i]) begin
            send_cpl(vecs[i].tag, vecs[i].len, vecs[i].exp_err);
            @(negedge clk);
            check("vec_rd_req", int'(tp.rd_req), vecs[i].exp_rd_req);
        end
        drain_one();
        drain_one();
        repeat (3) @(negedge clk);
        check("tag2_not_done", int'(tp.rd_req), 0);
        send_cpl(2, 10, 0);
        send_cpl(2, 6, 0);
        drain_one();
        check("empty_after_drain", int'(tp.empty), 1);

        // Pool limit: fifth request waits until the head tag is freed.
        do_reset();
        for (int i = 0; i < 4; i++) do_alloc(4, 1'b0);
        check("full_4", int'(tp.full), 1);
        tp.alloc_req  = 1'b1;
        tp.alloc_len  = LEN_W'(4);
        tp.alloc_last = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("held_no_ack", int'(tp.alloc_ack), 0);
        end
        send_cpl(0, 4, 0);
        drain_one();
        check("full_cleared", int'(tp.full), 0);
        n = 0;
        while (!tp.alloc_ack && n < 10) begin
            @(negedge clk);
            n++;
        end
        tp.alloc_req = 1'b0;
        check("late_ack", int'(tp.alloc_ack), 1);
        check("late_tag", int'(tp.alloc_tag), 4);
        e = '{tag: 4, len: 4, last: 0};
        exp_q.push_back(e);
        exp_tag   = 5;
        exp_outst = 4;
        check("outstanding_refill", int'(tp.outstanding), 4);

        // Reset while the drain is busy.
        send_cpl(1, 4, 0);
        n = 0;
        while (!tp.rd_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("busy_rd_tag", int'(tp.rd_tag), 1);
        tp.rd_ack = 1'b1;
        @(negedge clk);
        tp.rd_ack = 1'b0;
        do_reset();
        check("busy_rst_rd_req", int'(tp.rd_req), 0);
        check("busy_rst_empty", int'(tp.empty), 1);
        check("busy_rst_outstanding", int'(tp.outstanding), 0);
        send_cpl(2, 4, 1);

        // Forty tags in pairs: allocation and drain wrap 31 -> 0.
        for (int it = 0; it < 20; it++) begin
            t0 = exp_tag;
            do_alloc(2, 1'b0);
            do_alloc(3, it == 19);
            send_cpl((t0 + 1) % TAG_NUM, 3, 0);
            send_cpl(t0, 1, 0);
            send_cpl(t0, 1, 0);
            drain_one();
            drain_one();
        end
        check("wrap_next_tag", exp_tag, 8);

        // Zero-length request drains without any completion.
        do_alloc(0, 1'b1);
        drain_one();
        check("final_empty", int'(tp.empty), 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
